risc8_mem_arb: RTL and testbench
================================

RISC8_MEM_ARB -- requirements
Module: risc8_mem_arb

Interface
REQ-001 Parameter STARVE_MAX, default 3: consecutive denied port-1 request cycles before port 1 is forced a grant.
REQ-002 Parameter BURST_MAX, default 8: maximum consecutive locked port-1 grants while port 0 waits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 p0_req  input  1  datapath memory request.
REQ-006 p0_we  input  1  datapath write enable; 0 = read.
REQ-007 p0_addr  input  24  datapath word address.
REQ-008 p0_wdata  input  16  datapath write data.
REQ-009 p0_gnt  output  1  port-0 request accepted this cycle; low = datapath stall.
REQ-010 p0_rvalid  output  1  port-0 read data valid on rdata.
REQ-011 p1_req, p1_we, p1_addr[23:0], p1_wdata[15:0]  input  requester-1 (DMA/COM) request set, same meanings as port 0.
REQ-012 p1_lock  input  1  port 1 requests grant retention for a burst.
REQ-013 p1_gnt  output  1  port-1 request accepted this cycle.
REQ-014 p1_rvalid  output  1  port-1 read data valid on rdata.
REQ-015 rdata  output  16  read data, shared by both ports.
REQ-016 mem_en, mem_we  output  1 each  memory access strobe and write enable.
REQ-017 mem_addr  output  24;  mem_wr  output  16  memory address and write data.
REQ-018 mem_rd  input  16  synchronous memory read data, valid one cycle after a read strobe.

Function
REQ-019 Grant decision is combinational from the current req inputs and registered state; at most one of p0_gnt/p1_gnt is high in any cycle.
REQ-020 A port's gnt is never high unless its req is high.
REQ-021 Default priority: port 0 wins whenever p0_req=1, except as overridden by REQ-023 and REQ-024.
REQ-022 Granted cycle N: mem_en=1; mem_we, mem_addr and mem_wr equal the granted port's we, addr and wdata in cycle N. With no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wr=0.
REQ-023 Starvation counter (2 bits minimum, saturating at STARVE_MAX):
- Increments each cycle p1_req=1 and p1_gnt=0.
- Clears on any p1_gnt.
- When the counter equals STARVE_MAX, port 1 wins that cycle regardless of p0_req.
REQ-024 Lock states:
- FSM states: IDLE and LOCK1.
- IDLE -> LOCK1 on a port-1 grant with p1_lock=1.
- In LOCK1, port 1 wins while p1_req=1 and p1_lock=1.
- LOCK1 -> IDLE when p1_lock=0, when p1_req=0, or when the burst counter reaches BURST_MAX with p0_req=1.
- On the BURST_MAX exit, port 0 is granted in the next cycle.
REQ-025 Burst counter:
- Loads 1 on IDLE->LOCK1.
- Increments on each further locked grant, saturating at BURST_MAX.
- Clears in IDLE.
REQ-026 Read return: a granted read in cycle N gives pX_rvalid=1 for exactly cycle N+1, with rdata=mem_rd in N+1. Writes produce no rvalid.
REQ-027 Read returns are back-to-back capable: a read each cycle gives one rvalid per cycle, tagged to the correct port, with no bubbles.
REQ-028 rdata=0 whenever both rvalid outputs are 0.
REQ-029 Simultaneous requests, counter below STARVE_MAX, state IDLE: port 0 granted and the starvation counter increments.

Reset
REQ-030 While rst=1, asynchronously:
- All gnt, rvalid, mem_en and mem_we outputs = 0.
- mem_addr=0, mem_wr=0, rdata=0.
- FSM=IDLE; starvation and burst counters = 0.
REQ-031 Reset asserted mid-read drops the pending rvalid; no return is issued after deassertion.
REQ-032 First grant possible in the first rising edge cycle after rst deasserts.

Verification
REQ-033 p0 reads addr 0x000010 and mem returns 0x1234 the next cycle -> p0_gnt=1 in N; p0_rvalid=1 and rdata=0x1234 in N+1; p1 outputs stay 0.
REQ-034 p0_req and p1_req held high for 8 cycles, STARVE_MAX=3 -> grant sequence 0,0,0,1,0,0,0,1.
REQ-035 p1_lock=1 with continuous p1_req and p0_req, BURST_MAX=8, starting in IDLE with the starvation counter forced to 3 -> port 1 granted 8 consecutive cycles, then p0_gnt=1 in cycle 9.
REQ-036 Alternating p0 read / p1 read every cycle -> rvalid alternates p0/p1 one cycle later, each with matching mem_rd data.
REQ-037 rst pulsed in the cycle after a p1 read grant -> p1_rvalid never asserts; all outputs 0 during reset.
REQ-038 p1 write 0xBEEF to 0xFF0001 with p0_req=0 -> mem_en=1, mem_we=1, mem_addr=0xFF0001, mem_wr=0xBEEF in the same cycle; no rvalid.

Source files
------------

// File: rtl/risc8_mem_arb.sv
// Two-port memory arbiter for the RISC8 core. Port 0 is the datapath and port 1 is DMA/COM.
// Port 1 has starvation relief and a locked-burst mode. Read data returns one cycle after the grant.
module risc8_mem_arb #(
  parameter int STARVE_MAX = 3,
  parameter int BURST_MAX  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [23:0] p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [23:0] p1_addr,
  input  logic [15:0] p1_wdata,
  input  logic        p1_lock,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [15:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_wr,
  input  logic [15:0] mem_rd
);

  localparam int SW = (STARVE_MAX < 3) ? 2 : $clog2(STARVE_MAX + 1);
  localparam int BW = (BURST_MAX < 2) ? 1 : $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);

  typedef enum logic {IDLE, LOCK1} state_t;

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_starve, w_starve_nxt;
  logic [BW-1:0] r_burst, w_burst_nxt;
  logic          r_rv0, r_rv1;

  logic w_starved, w_burst_full, w_locked;
  logic w_p0_gnt, w_p1_gnt;

  assign w_starved    = (r_starve == STARVE_LIM);
  assign w_burst_full = (r_burst == BURST_LIM);
  // A full burst only yields when port 0 is actually waiting; otherwise the lock keeps running.
  assign w_locked     = (r_state == LOCK1) & p1_lock & ~(w_burst_full & p0_req);

  // Grants are gated by rst so every output is quiet while reset is held.
  assign w_p1_gnt = ~rst & p1_req & (w_starved | w_locked | ~p0_req);
  assign w_p0_gnt = ~rst & p0_req & ~w_p1_gnt;

  assign p0_gnt = w_p0_gnt;
  assign p1_gnt = w_p1_gnt;

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst;
    case (r_state)
      IDLE: begin
        w_burst_nxt = '0;
        if (w_p1_gnt & p1_lock) begin
          w_state_nxt = LOCK1;
          w_burst_nxt = BW'(1);
        end
      end
      LOCK1: begin
        if (w_p1_gnt & w_locked) begin
          if (!w_burst_full) w_burst_nxt = r_burst + BW'(1);
        end else begin
          w_state_nxt = IDLE;
          w_burst_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_burst_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_p1_gnt)
      w_starve_nxt = '0;
    else if (p1_req && !w_starved)
      w_starve_nxt = r_starve + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_burst  <= '0;
      r_rv0    <= 1'b0;
      r_rv1    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_burst  <= w_burst_nxt;
      r_rv0    <= w_p0_gnt & ~p0_we;
      r_rv1    <= w_p1_gnt & ~p1_we;
    end
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wr   = '0;
    if (w_p0_gnt) begin
      mem_en   = 1'b1;
      mem_we   = p0_we;
      mem_addr = p0_addr;
      mem_wr   = p0_wdata;
    end else if (w_p1_gnt) begin
      mem_en   = 1'b1;
      mem_we   = p1_we;
      mem_addr = p1_addr;
      mem_wr   = p1_wdata;
    end
  end

  assign p0_rvalid = r_rv0;
  assign p1_rvalid = r_rv1;
  assign rdata     = (r_rv0 | r_rv1) ? mem_rd : '0;

endmodule

// File: tb/tb_risc8_mem_arb.sv
// Directed bench for risc8_mem_arb. A queue holds the read return expected in the following cycle.
module tb_risc8_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we, p1_lock;
  logic [23:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [15:0] rdata;
  logic        mem_en, mem_we;
  logic [23:0] mem_addr;
  logic [15:0] mem_wr;
  logic [15:0] mem_rd = 16'h0000;

  typedef struct packed {
    logic [1:0]  rv;
    logic [15:0] d;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] cur_g;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  risc8_mem_arb #(.STARVE_MAX(3), .BURST_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wr(mem_wr), .mem_rd(mem_rd)
  );

  function automatic logic [15:0] memf(input logic [23:0] a);
    return (a == 24'h000010) ? 16'h1234 : (a[15:0] ^ 16'h5A5A);
  endfunction

  // Synchronous memory model; the filler value exposes rdata that is not gated to 0.
  always @(posedge clk)
    mem_rd <= (mem_en && !mem_we) ? memf(mem_addr) : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [23:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic [23:0] a1, input logic [15:0] d1,
                       input logic lk, input logic [1:0] g);
    exp_t e;
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_lock = lk;
    cur_g = g;
    e = '0;
    if (g[0] && !w0) e = '{rv: 2'b01, d: memf(a0)};
    else if (g[1] && !w1) e = '{rv: 2'b10, d: memf(a1)};
    sb.push_back(e);
  endtask

  task automatic check_cycle(input string tag);
    exp_t        e;
    logic        x_we;
    logic [23:0] x_addr;
    logic [15:0] x_wr;
    @(negedge clk);
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    x_we = 1'b0; x_addr = '0; x_wr = '0;
    if (cur_g[0]) begin x_we = p0_we; x_addr = p0_addr; x_wr = p0_wdata; end
    else if (cur_g[1]) begin x_we = p1_we; x_addr = p1_addr; x_wr = p1_wdata; end
    chk({tag, ".p0_gnt"},    32'(p0_gnt),    32'(cur_g[0]));
    chk({tag, ".p1_gnt"},    32'(p1_gnt),    32'(cur_g[1]));
    chk({tag, ".mem_en"},    32'(mem_en),    32'(|cur_g));
    chk({tag, ".mem_we"},    32'(mem_we),    32'(x_we));
    chk({tag, ".mem_addr"},  32'(mem_addr),  32'(x_addr));
    chk({tag, ".mem_wr"},    32'(mem_wr),    32'(x_wr));
    chk({tag, ".p0_rvalid"}, 32'(p0_rvalid), 32'(e.rv[0]));
    chk({tag, ".p1_rvalid"}, 32'(p1_rvalid), 32'(e.rv[1]));
    chk({tag, ".rdata"},     32'(rdata),     32'(e.d));
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag,
                     input logic r0, input logic w0, input logic [23:0] a0, input logic [15:0] d0,
                     input logic r1, input logic w1, input logic [23:0] a1, input logic [15:0] d1,
                     input logic lk, input logic [1:0] g);
    drive(r0, w0, a0, d0, r1, w1, a1, d1, lk, g);
    check_cycle(tag);
    adv();
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 2'b00);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".p0_gnt"},    32'(p0_gnt),    32'(1'b0));
    chk({tag, ".p1_gnt"},    32'(p1_gnt),    32'(1'b0));
    chk({tag, ".mem_en"},    32'(mem_en),    32'(1'b0));
    chk({tag, ".mem_we"},    32'(mem_we),    32'(1'b0));
    chk({tag, ".mem_addr"},  32'(mem_addr),  32'(24'h0));
    chk({tag, ".mem_wr"},    32'(mem_wr),    32'(16'h0));
    chk({tag, ".p0_rvalid"}, 32'(p0_rvalid), 32'(1'b0));
    chk({tag, ".p1_rvalid"}, 32'(p1_rvalid), 32'(1'b0));
    chk({tag, ".rdata"},     32'(rdata),     32'(16'h0));
  endtask

  initial begin
    // Reset with both requesters active: outputs must still be quiet.
    rst = 1'b1;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 24'h123456; p0_wdata = 16'h1111;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 24'h654321; p1_wdata = 16'h2222; p1_lock = 1'b1;
    cur_g = 2'b00;
    #2;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset_hold");
    p0_req = 1'b0; p1_req = 1'b0; p1_lock = 1'b0;
    rst = 1'b0;
    sb.delete();
    sb.push_back('0);
    adv();

    // Single p0 read with known return data.
    cyc("p0_read", 1'b1, 1'b0, 24'h000010, 16'h0, 1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 2'b01);
    idle("p0_read_ret");

    // p1 write with port 0 idle.
    cyc("p1_write", 1'b0, 1'b0, 24'h0, 16'h0, 1'b1, 1'b1, 24'hFF0001, 16'hBEEF, 1'b0, 2'b10);
    idle("p1_write_ret");

    // Contention: starvation relief every fourth cycle.
    begin
      logic [1:0] pat [8];
      pat = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
      for (int i = 0; i < 8; i++)
        cyc($sformatf("starve%0d", i), 1'b1, 1'b0, 24'h000100 + 24'(i), 16'h0,
            1'b1, 1'b0, 24'h000200 + 24'(i), 16'h0, 1'b0, pat[i]);
    end
    idle("starve_ret");

    // Alternating single-port reads; returns are back to back.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        cyc($sformatf("alt%0d", i), 1'b1, 1'b0, 24'h000A00 + 24'(i), 16'h0,
            1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 2'b01);
      else
        cyc($sformatf("alt%0d", i), 1'b0, 1'b0, 24'h0, 16'h0,
            1'b1, 1'b0, 24'h000B00 + 24'(i), 16'h0, 1'b0, 2'b10);
    end
    idle("alt_ret");

    // Locked burst: three starved cycles, eight locked p1 grants, then port 0 is released.
    for (int i = 0; i < 13; i++) begin
      logic [1:0] g;
      g = (i >= 3 && i <= 10) ? 2'b10 : 2'b01;
      cyc($sformatf("burst%0d", i), 1'b1, 1'b1, 24'h000300 + 24'(i), 16'h7000 + 16'(i),
          1'b1, 1'b0, 24'h000400 + 24'(i), 16'h0, 1'b1, g);
    end
    idle("burst_ret");

    // Lock held with port 0 idle, kept against p0, then dropped.
    cyc("lk0", 1'b0, 1'b0, 24'h0,      16'h0,    1'b1, 1'b0, 24'h000C00, 16'h0,    1'b1, 2'b10);
    cyc("lk1", 1'b0, 1'b0, 24'h0,      16'h0,    1'b1, 1'b1, 24'h000C01, 16'hAAAA, 1'b1, 2'b10);
    cyc("lk2", 1'b1, 1'b0, 24'h000D02, 16'h0,    1'b1, 1'b0, 24'h000C02, 16'h0,    1'b1, 2'b10);
    cyc("lk3", 1'b1, 1'b0, 24'h000D03, 16'h0,    1'b1, 1'b0, 24'h000C03, 16'h0,    1'b0, 2'b01);
    cyc("lk4", 1'b1, 1'b1, 24'h000D04, 16'h5555, 1'b1, 1'b0, 24'h000C04, 16'h0,    1'b0, 2'b01);
    idle("lk_ret");

    // Reset right after a p1 read grant: the return must be dropped.
    drive(1'b0, 1'b0, 24'h0, 16'h0, 1'b1, 1'b0, 24'h000500, 16'h0, 1'b0, 2'b10);
    check_cycle("rst_p1rd");
    rst = 1'b1;
    sb.delete();
    #1;
    chk_zero("rst_mid");
    @(posedge clk);
    @(negedge clk);
    chk_zero("rst_mid_hold");
    p1_req = 1'b0;
    rst = 1'b0;
    sb.push_back('0);
    adv();
    idle("rst_noret");
    cyc("first_gnt", 1'b1, 1'b0, 24'h000600, 16'h0, 1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 2'b01);
    idle("first_gnt_ret");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
